// File: rtl/imm_pkg.sv
// Shared constants for the constant-to-immediate splitter: opcodes, FSM encoding
// and the elaboration-time width check.
package imm_pkg;

    localparam logic OP_LUI = 1'b0;
    localparam logic OP_ORI = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_UPPER = 2'd1;
    localparam logic [1:0] ST_LOWER = 2'd2;

    function automatic bit width_ok(input int n);
        return (n >= 2) && ((n % 2) == 0);
    endfunction

endpackage

// File: rtl/imm_split_n.sv
// Splits an N-bit constant into an upper-half LUI beat and, when the lower half
// is non-zero, a following ORI beat for the register-write issue logic.
module imm_split_n
    import imm_pkg::*;
#(
    parameter int N  = 8,
    parameter int RW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic [RW-1:0]  in_rd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_op,
    output logic [N/2-1:0] out_imm,
    output logic [RW-1:0]  out_rd,
    output logic           busy
);

    localparam int HALF = N / 2;

    if (!width_ok(N)) begin : g_bad_n
        $error("imm_split_n: N must be even and at least 2");
    end

    logic [1:0]      state;
    logic [HALF-1:0] lo_q;
    logic            lo_nz;
    logic            last_beat;
    logic            accept;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Producers never drop valid or change payload until that edge; in_ready
    // is independent of in_valid, and out_* come only from registers.
    assign last_beat = (state == ST_LOWER) || ((state == ST_UPPER) && !lo_nz);
    assign in_ready  = (state == ST_IDLE) || (out_ready && last_beat);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_op    <= OP_LUI;
            out_imm   <= '0;
            out_rd    <= '0;
            lo_q      <= '0;
            lo_nz     <= 1'b0;
        end else if (accept) begin
            // Fresh constant, possibly overlapping the previous one's last handshake.
            state     <= ST_UPPER;
            out_valid <= 1'b1;
            out_op    <= OP_LUI;
            out_imm   <= in_data[N-1:HALF];
            out_rd    <= in_rd;
            lo_q      <= in_data[HALF-1:0];
            lo_nz     <= |in_data[HALF-1:0];
        end else if ((state == ST_UPPER) && out_ready && lo_nz) begin
            state     <= ST_LOWER;
            out_op    <= OP_ORI;
            out_imm   <= lo_q;
        end else if (out_ready && last_beat) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/imm_split_n.md
# imm_split_n

Constant-to-immediate splitter for the datapath's constant-load path. Accepts a full N-bit constant plus a destination register index over a valid/ready handshake. Emits it as an instruction-like beat stream: an upper-half LUI beat, then, only if the lower half is non-zero, a lower-half ORI beat. Sits between the constant source (assembler/decoder front end) and the register-write issue logic, producing the inverse of the upper-immediate load.

## Interface
- `N`, default 8: constant width; must be even and ≥ 2.
- `RW`, default 4: destination register index width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: source holds a constant.
- `in_ready` output 1: splitter accepts this cycle.
- `in_data` input N: constant to load.
- `in_rd` input RW: destination register.
- `out_valid` output 1: beat presented.
- `out_ready` input 1: consumer takes beat this cycle.
- `out_op` output 1: 0 = LUI (rd ← imm << N/2), 1 = ORI (rd ← rd | imm).
- `out_imm` output N/2: immediate half.
- `out_rd` output RW: destination register of beat.
- `busy` output 1: a constant is in flight (state ≠ IDLE).

## Operation
- FSM states: IDLE, UPPER, LOWER.
- Reset (async, `rst_n` low): state IDLE; `out_valid`, `out_op`, `out_imm`, `out_rd` all 0; internal lower-half holding register 0; `busy` 0.
- Accept occurs when `in_valid` && `in_ready`. On accept:
  - latch `in_data[N-1:N/2]` into `out_imm`; set `out_op` = 0; latch `in_rd`; set `out_valid` = 1.
  - latch `in_data[N/2-1:0]` into the lower holding register; set flag `lo_nz` = (lower half ≠ 0).
  - go to UPPER.
- UPPER, on `out_ready`:
  - if `lo_nz`: present ORI beat (`out_op` = 1, `out_imm` = lower half, same `out_rd`) and go to LOWER.
  - else: the beat is last; treat as LOWER completion.
- LOWER, on `out_ready`: the beat is last.
- Last-beat completion: if a new accept happens the same cycle, load the new constant's LUI beat and go to UPPER, with `out_valid` staying 1. Otherwise clear `out_valid` and go to IDLE.
- `in_ready` is combinational: IDLE, or (`out_ready` && current beat is last), where last = LOWER, or UPPER with `lo_nz` = 0. It never depends on `in_valid`.
- While `out_valid` && !`out_ready`: `out_op`, `out_imm`, `out_rd` held stable, no state change.
- Zero constant (0): single LUI beat with imm 0. Upper-zero/lower-nonzero: still LUI 0 followed by ORI, so rd is fully defined.
- `busy` = (state ≠ IDLE).

## Timing
- Latency: accept at edge k → LUI beat visible (`out_valid` = 1) from k+1.
- ORI beat follows the LUI handshake by exactly one cycle when `out_ready` is held high.
- Throughput with `out_ready` high:
  - one constant per cycle if all lower halves are zero;
  - one per two cycles otherwise.
  - No bubble between consecutive constants.
- Asynchronous reset mid-operation (UPPER or LOWER): the in-flight constant is dropped. Outputs clear immediately without waiting for a clock edge. The first accept is possible at the first edge after `rst_n` rises.
- No combinational path from `in_*` to `out_*`. One combinational path exists, from `out_ready` to `in_ready`.

## Structure
- Shared package `imm_pkg`:
  - opcode constants `OP_LUI` = 1'b0, `OP_ORI` = 1'b1;
  - state encoding `ST_IDLE` = 2'd0, `ST_UPPER` = 2'd1, `ST_LOWER` = 2'd2;
  - parameter checks (N even).
- Single module. No sub-module is warranted; the half-selection is trivial slicing inside the FSM.

## Test plan
- N=8, accept `in_data` 8'hA5, `in_rd` 3, `out_ready` = 1 → cycle k+1 LUI/4'hA/rd 3, cycle k+2 ORI/4'h5/rd 3, then `out_valid` 0 and `busy` 0.
- Accept 8'h30, then 8'h00 back-to-back with `out_ready` = 1:
  - single LUI 4'h3, then single LUI 4'h0 on the next cycle;
  - `in_ready` stays 1 throughout, no idle cycle.
- Accept 8'h0F → LUI 4'h0, then ORI 4'hF (upper-zero still emits LUI).
- 8'hC7 with `out_ready` low for 3 cycles during the LUI beat:
  - LUI/4'hC held stable, `in_ready` 0;
  - after release, ORI/4'h7 appears next cycle.
- Pipelined: 8'h12 then 8'h34, `in_valid` held, `out_ready` = 1 → LUI 1, ORI 2, LUI 3, ORI 4 on four consecutive cycles; the second accept coincides with the ORI 2 handshake.
- Assert `rst_n` low asynchronously (between edges) while in LOWER:
  - `out_valid`, `busy`, `out_imm` go to 0 immediately;
  - after release, accepting 8'h81 yields LUI 4'h8, then ORI 4'h1 with no residue.
